hazard_stall_controller: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core. It sits beside the ID stage and its ID/EX stage register. It detects load-use hazards, branch redirects and data-memory wait states, and drives the PC/IF-ID write enables, the ID/EX bubble and the per-stage flushes. It also keeps stall/flush statistics and a sticky memory-timeout error for debug.

---
 rtl/hazard_stall_controller.sv | 90 +++++++++
 tb/tb_hazard_stall_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use/branch/memory-wait pipeline sequencing with stall/flush stats
module hazard_stall_controller #(
  parameter int CNT_W = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instruction,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_write_reg,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             err_timeout
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH_PEND = 2'd2} state_t;
  state_t cur, nxt;
  logic pend_flush, pend_nxt, uses_rt, lu, flush;
  logic [7:0] wait_cnt, wait_inc;
  logic [5:0] opcode;
  logic [4:0] rs, rt;
  assign opcode = id_instruction[31:26];
  assign rs = id_instruction[25:21];
  assign rt = id_instruction[20:16];
  assign uses_rt = (opcode == 6'h00) || (opcode == 6'h2B) || (opcode == 6'h04) || (opcode == 6'h05);
  assign lu = ex_MemRead && (ex_write_reg != 5'd0) && ((ex_write_reg == rs) || (uses_rt && ex_write_reg == rt));
  assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  assign state = cur;
  assign if_id_flush = flush;
  assign id_ex_flush = flush;
  assign ex_mem_flush = flush;
  always_comb begin
    pc_write = 1'b1;
    if_id_write = 1'b1;
    id_ex_bubble = 1'b0;
    flush = 1'b0;
    pipe_hold = 1'b0;
    nxt = RUN;
    pend_nxt = pend_flush;
    if (reset) begin
      pend_nxt = 1'b0;
    end else if (cur == RUN || cur == MEM_WAIT) begin
      // pend_flush is always clear in RUN, so RUN and the MEM_WAIT exit share one path
      if (mem_busy) begin
        pipe_hold = 1'b1;
        pc_write = 1'b0;
        if_id_write = 1'b0;
        nxt = MEM_WAIT;
        pend_nxt = pend_flush | branch_taken;
      end else begin
        flush = branch_taken;
        id_ex_bubble = !branch_taken && lu;
        pc_write = branch_taken || !lu;
        if_id_write = branch_taken || !lu;
        nxt = pend_flush ? FLUSH_PEND : RUN;
      end
    end else if (cur == FLUSH_PEND) begin
      flush = 1'b1;
      pipe_hold = mem_busy;
      pend_nxt = 1'b0;
      nxt = mem_busy ? MEM_WAIT : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= RUN;
      pend_flush <= 1'b0;
      wait_cnt <= 8'd0;
      stall_count <= '0;
      flush_count <= '0;
      err_timeout <= 1'b0;
    end else begin
      cur <= nxt;
      pend_flush <= pend_nxt;
      wait_cnt <= (nxt == RUN) ? 8'd0 : (cur == MEM_WAIT) ? wait_inc : wait_cnt;
      err_timeout <= err_timeout || (cur == MEM_WAIT && int'(wait_inc) >= MEM_TIMEOUT);
      if (id_ex_bubble && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
      if (flush && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: scoreboard of per-cycle control vectors plus inline counter/error checks
module tb_hazard_stall_controller;
  logic clk = 1'b0, reset = 1'b0, ex_MemRead = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
  logic [31:0] id_instruction = 32'd0;
  logic [4:0] ex_write_reg = 5'd0;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold, err_timeout;
  logic [1:0] state;
  logic [15:0] stall_count, flush_count;
  int checks = 0, errors = 0;
  typedef struct {logic [8:0] v; logic [8:0] m;} exp_t;
  exp_t sb[$];
  // vector: {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold, state}
  localparam logic [8:0] RUN_N = 9'b110000000, STALL = 9'b001000000, BR_RUN = 9'b110111000;
  localparam logic [8:0] HOLD_RUN = 9'b000000100, HOLD_WAIT = 9'b000000101, EXIT_W = 9'b110000001;
  localparam logic [8:0] FP = 9'b110111010, FP_BUSY = 9'b110111110, NOSTATE = 9'b111111100;
  localparam logic [31:0] ADD8 = {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] ADD0 = {6'h00, 5'd0, 5'd9, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] SW_RT8 = {6'h2B, 5'd3, 5'd8, 16'h0};
  localparam logic [31:0] ADDI = {6'h08, 5'd9, 5'd8, 16'h4};
  localparam logic [31:0] LW_RT8 = {6'h23, 5'd3, 5'd8, 16'h0};

  hazard_stall_controller #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .id_instruction(id_instruction), .ex_MemRead(ex_MemRead),
    .ex_write_reg(ex_write_reg), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .pipe_hold(pipe_hold), .state(state), .stall_count(stall_count), .flush_count(flush_count),
    .err_timeout(err_timeout));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [8:0] obs;
      e = sb.pop_front();
      obs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold, state};
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL ctrl t=%0t got=%b want=%b mask=%b", $time, obs, e.v, e.m);
      end
    end
  end

  task automatic cyc(input logic r, input logic [31:0] ins, input logic mr, input logic [4:0] wr,
                     input logic br, input logic mb, input logic [8:0] ev, input logic [8:0] em = 9'h1FF);
    reset = r; id_instruction = ins; ex_MemRead = mr; ex_write_reg = wr; branch_taken = br; mem_busy = mb;
    sb.push_back('{ev, em});
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    cyc(1, ADD8, 1, 8, 1, 1, RUN_N, NOSTATE);
    cyc(1, ADD8, 1, 8, 1, 1, RUN_N);
    cyc(0, ADD8, 0, 0, 0, 0, RUN_N);
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got=%0d/%0d/%b want=0/0/0", stall_count, flush_count, err_timeout);
    end
  endtask

  task automatic test_no_false;
    cyc(0, ADD0, 1, 0, 0, 0, RUN_N);
    cyc(0, ADDI, 1, 8, 0, 0, RUN_N);
    cyc(0, LW_RT8, 1, 8, 0, 0, RUN_N);
    checks++;
    if (stall_count !== 16'd0) begin
      errors++;
      $display("FAIL no_false_stall got=%0d want=0", stall_count);
    end
  endtask

  task automatic test_load_use;
    cyc(0, ADD8, 1, 8, 0, 0, STALL);
    cyc(0, ADD8, 0, 0, 0, 0, RUN_N);
    checks++;
    if (stall_count !== 16'd1) begin
      errors++;
      $display("FAIL lu_rs_count got=%0d want=1", stall_count);
    end
    cyc(0, SW_RT8, 1, 8, 0, 0, STALL);
    cyc(0, SW_RT8, 0, 8, 0, 0, RUN_N);
    checks++;
    if (stall_count !== 16'd2) begin
      errors++;
      $display("FAIL lu_rt_count got=%0d want=2", stall_count);
    end
  endtask

  task automatic test_branch;
    cyc(0, ADD8, 1, 8, 1, 0, BR_RUN);
    cyc(0, ADD8, 0, 0, 0, 0, RUN_N);
    checks++;
    if (flush_count !== 16'd1 || stall_count !== 16'd2) begin
      errors++;
      $display("FAIL branch_counts got=%0d/%0d want=1/2", flush_count, stall_count);
    end
  endtask

  task automatic test_mem_wait_branch;
    cyc(0, ADD8, 0, 0, 0, 1, HOLD_RUN);
    cyc(0, ADD8, 0, 0, 1, 1, HOLD_WAIT);
    cyc(0, ADD8, 0, 0, 0, 1, HOLD_WAIT);
    cyc(0, ADD8, 0, 0, 0, 1, HOLD_WAIT);
    cyc(0, ADD8, 0, 0, 0, 0, EXIT_W);
    cyc(0, ADD8, 0, 0, 0, 0, FP);
    cyc(0, ADD8, 0, 0, 0, 0, RUN_N);
    checks++;
    if (flush_count !== 16'd2) begin
      errors++;
      $display("FAIL wait_flush_count got=%0d want=2", flush_count);
    end
  endtask

  task automatic test_back_to_back;
    cyc(0, ADD8, 0, 0, 1, 0, BR_RUN);
    cyc(0, ADD8, 0, 0, 1, 0, BR_RUN);
    cyc(0, ADD8, 0, 0, 1, 1, HOLD_RUN);
    cyc(0, ADD8, 0, 0, 0, 0, EXIT_W);
    cyc(0, ADD8, 0, 0, 0, 1, FP_BUSY);
    cyc(0, ADD8, 0, 0, 0, 0, EXIT_W);
    cyc(0, ADD8, 0, 0, 0, 0, RUN_N);
    checks++;
    if (flush_count !== 16'd5) begin
      errors++;
      $display("FAIL b2b_flush_count got=%0d want=5", flush_count);
    end
  endtask

  task automatic test_timeout;
    cyc(0, ADD8, 0, 0, 0, 1, HOLD_RUN);
    for (int k = 1; k <= 19; k++) begin
      if (k == 15 || k == 16) begin
        checks++;
        if (err_timeout !== (k >= 16)) begin
          errors++;
          $display("FAIL timeout_edge k=%0d got=%b want=%b", k, err_timeout, k >= 16);
        end
      end
      cyc(0, ADD8, 0, 0, 0, 1, HOLD_WAIT);
    end
    cyc(0, ADD8, 0, 0, 0, 0, EXIT_W);
    cyc(0, ADD8, 0, 0, 0, 0, RUN_N);
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got=%b want=1", err_timeout);
    end
    cyc(1, ADD8, 0, 0, 0, 0, RUN_N);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got=%b want=0", err_timeout);
    end
  endtask

  task automatic test_reset_mid_wait;
    cyc(0, ADD8, 0, 0, 0, 0, RUN_N);
    cyc(0, ADD8, 0, 0, 1, 1, HOLD_RUN);
    cyc(0, ADD8, 0, 0, 0, 1, HOLD_WAIT);
    cyc(1, ADD8, 1, 8, 1, 1, RUN_N, NOSTATE);
    cyc(0, ADD8, 0, 0, 0, 0, RUN_N);
    cyc(0, ADD8, 0, 0, 0, 0, RUN_N);
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_reset got=%0d/%0d/%b want=0/0/0", stall_count, flush_count, err_timeout);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_no_false;
    test_load_use;
    test_branch;
    test_mem_wait_branch;
    test_back_to_back;
    test_timeout;
    test_reset_mid_wait;
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
